// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multi-cycle multiplier sequencer sitting behind the EX stage.
// Optional MULACC_EN macro enables MADD(U)/MSUB(U) accumulate on commit.
module hilo_muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_mul_req,
  input  logic                ex_mul_sign,
  input  logic [DATA_W-1:0]   ex_a,
  input  logic [DATA_W-1:0]   ex_b,
  input  logic                ex_mthi,
  input  logic                ex_mtlo,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [1:0]          ex_acc_op,
  input  logic                flush,
  output logic                stall_o,
  output logic                mul_opn_valid,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  output logic                mul_sign,
  input  logic                mul_res_valid,
  output logic                mul_res_ready,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e              state_q;
  logic                kill_q;
  logic                opn_valid_q;
  logic                res_ready_q;
  logic [DATA_W-1:0]   mul_a_q;
  logic [DATA_W-1:0]   mul_b_q;
  logic                mul_sign_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [2*DATA_W-1:0] hilo_d;
  logic                busy;
  logic                accept_mul;
  logic                mt_ok;
  logic                commit;

`ifdef MULACC_EN
  logic [1:0] acc_q;

  always_comb begin
    hilo_d = mul_result;
    case (acc_q)
      2'b01:   hilo_d = {hi_q, lo_q} + mul_result;
      2'b10:   hilo_d = {hi_q, lo_q} - mul_result;
      default: hilo_d = mul_result;
    endcase
  end
`else
  logic unused_acc_op;
  assign unused_acc_op = ^ex_acc_op;

  always_comb begin
    hilo_d = mul_result;
  end
`endif

  assign busy       = (state_q == ISSUE) || (state_q == WAIT);
  assign accept_mul = (state_q == IDLE) && ex_mul_req && !flush;
  // MT writes are legal once the product has landed, so DRAIN accepts them too.
  assign mt_ok      = ((state_q == IDLE) || (state_q == DRAIN)) && !ex_mul_req && !flush;
  assign commit     = (state_q == WAIT) && mul_res_valid && !kill_q && !flush;

  assign stall_o       = !flush && (busy || ex_mul_req);
  assign mul_opn_valid = opn_valid_q;
  assign mul_res_ready = res_ready_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign mul_sign      = mul_sign_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      opn_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_sign_q  <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
`ifdef MULACC_EN
      acc_q       <= 2'b00;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_mul) begin
            mul_a_q     <= ex_a;
            mul_b_q     <= ex_b;
            mul_sign_q  <= ex_mul_sign;
`ifdef MULACC_EN
            acc_q       <= ex_acc_op;
`endif
            opn_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          opn_valid_q <= 1'b0;
          res_ready_q <= 1'b1;
          kill_q      <= kill_q | flush;
          state_q     <= WAIT;
        end
        WAIT: begin
          kill_q <= kill_q | flush;
          if (mul_res_valid) begin
            state_q <= DRAIN;
            if (commit) begin
              {hi_q, lo_q} <= hilo_d;
            end
          end
        end
        DRAIN: begin
          // The multiplier holds res_valid a few cycles past the handshake.
          if (!mul_res_valid) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            res_ready_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (mt_ok && ex_mthi) begin
        hi_q <= ex_wdata;
      end
      if (mt_ok && ex_mtlo) begin
        lo_q <= ex_wdata;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed scenarios plus randomized
// instruction streams against an instruction-level HI/LO model (MULACC_EN aware).
module tb_hilo_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_mul_req;
  logic        ex_mul_sign;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_mthi;
  logic        ex_mtlo;
  logic [31:0] ex_wdata;
  logic [1:0]  ex_acc_op;
  logic        flush;
  logic        stall_o;
  logic        mul_opn_valid;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sign;
  logic        mul_res_valid;
  logic        mul_res_ready;
  logic [63:0] mul_result;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

`ifdef MULACC_EN
  localparam bit MacEn = 1'b1;
`else
  localparam bit MacEn = 1'b0;
`endif

  hilo_muldiv_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_mul_req(ex_mul_req), .ex_mul_sign(ex_mul_sign),
    .ex_a(ex_a), .ex_b(ex_b),
    .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo), .ex_wdata(ex_wdata),
    .ex_acc_op(ex_acc_op), .flush(flush),
    .stall_o(stall_o),
    .mul_opn_valid(mul_opn_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_sign(mul_sign),
    .mul_res_valid(mul_res_valid), .mul_res_ready(mul_res_ready), .mul_result(mul_result),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level view: is a multiply outstanding, has it landed, what HI/LO must hold.
  bit          mInflight, mIssue, mDrain, mKill, mSign;
  logic [31:0] mHi, mLo, mA, mB;
  logic [1:0]  mAcc;
  bit          accEdge, hsEdge, mtEdge;

  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] commitValue(input logic [63:0] old, input logic [63:0] p, input logic [1:0] acc);
    if (MacEn && acc == 2'b01) return old + p;
    if (MacEn && acc == 2'b10) return old - p;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit wasDrain;
    accEdge = 0;
    hsEdge  = 0;
    mtEdge  = 0;
    if (rst) begin
      mInflight = 0; mIssue = 0; mDrain = 0; mKill = 0;
      mHi = 0; mLo = 0; mA = 0; mB = 0; mSign = 0; mAcc = 0;
    end else if (mInflight) begin
      if (!mIssue && mul_res_valid) begin
        if (!mKill && !flush) {mHi, mLo} = commitValue({mHi, mLo}, product(mA, mB, mSign), mAcc);
        mInflight = 0;
        mDrain    = 1;
        hsEdge    = 1;
      end
      if (flush) mKill = 1;
      mIssue = 0;
    end else begin
      wasDrain = mDrain;
      if (mDrain && !mul_res_valid) begin
        mDrain = 0;
        mKill  = 0;
      end
      if (!wasDrain && ex_mul_req && !flush) begin
        mInflight = 1; mIssue = 1;
        mA = ex_a; mB = ex_b; mSign = ex_mul_sign; mAcc = ex_acc_op;
        accEdge = 1;
      end else if (!ex_mul_req && !flush && (ex_mthi || ex_mtlo)) begin
        if (ex_mthi) mHi = ex_wdata;
        if (ex_mtlo) mLo = ex_wdata;
        mtEdge = 1;
      end
    end
  end

  // Multiplier environment: reacts to the start pulse with a variable latency.
  logic        sOpn, sRdy, sSign;
  logic [31:0] sA, sB;
  bit          eBusy, eTail;
  int          eDelay, eTailCnt;
  logic [63:0] eProd;

  always @(negedge clk) begin
    sOpn  = mul_opn_valid;
    sRdy  = mul_res_ready;
    sA    = mul_a;
    sB    = mul_b;
    sSign = mul_sign;
    if (checkEn) begin
      checkOutput("stall", stall_o, !flush && (ex_mul_req || mInflight));
      checkOutput("opn_valid", mul_opn_valid, mIssue);
      checkOutput("res_ready", mul_res_ready, (mInflight && !mIssue) || mDrain);
      checkOutput("hi", hi_o, mHi);
      checkOutput("lo", lo_o, mLo);
      checkOutput("mul_a", mul_a, mA);
      checkOutput("mul_b", mul_b, mB);
      checkOutput("mul_sign", mul_sign, mSign);
    end
  end

  initial begin
    mul_res_valid = 1'b0;
    mul_result    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mul_res_valid = 1'b0;
        eBusy = 0;
        eTail = 0;
      end else begin
        if (eTail) begin
          eTailCnt--;
          if (eTailCnt == 0) begin
            mul_res_valid = 1'b0;
            eTail = 0;
          end
        end else if (mul_res_valid && sRdy) begin
          eTail      = 1;
          eTailCnt   = $urandom_range(1, 3);
          mul_result = {$urandom, $urandom};
        end else if (eBusy) begin
          if (eDelay == 0) begin
            mul_res_valid = 1'b1;
            mul_result    = eProd;
            eBusy = 0;
          end else begin
            eDelay--;
          end
        end
        if (sOpn) begin
          eBusy  = 1;
          eDelay = $urandom_range(0, 3);
          eProd  = product(sA, sB, sSign);
        end
      end
    end
  end

  task automatic applyStimulus(input bit req, input bit sign, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] acc, input bit hi, input bit lo, input logic [31:0] wd,
                               input bit fl);
    ex_mul_req  = req;
    ex_mul_sign = sign;
    ex_a        = a;
    ex_b        = b;
    ex_acc_op   = acc;
    ex_mthi     = hi;
    ex_mtlo     = lo;
    ex_wdata    = wd;
    flush       = fl;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL timeout_%s actual=expired required=event", name);
  endtask

  // Holds one EX instruction until it leaves EX (accept, commit or MT write).
  task automatic runInstr(input bit isMul, input bit sign, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] acc, input bit hi, input bit lo, input logic [31:0] wd,
                          input bit holdToCommit, input int flushPct, input string tag);
    bit done;
    bit accepted;
    bit fl;
    done = 0;
    accepted = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      fl = (flushPct > 0) && ($urandom_range(0, 99) < flushPct);
      applyStimulus(isMul, sign, a, b, acc, hi && !isMul, lo && !isMul, wd, fl);
      nextCycle();
      if (isMul) begin
        if (accEdge) accepted = 1;
        done = holdToCommit ? (accepted && hsEdge) : accepted;
      end else begin
        done = mtEdge;
      end
    end
    if (!done) failTimeout(tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic waitIdle(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      nextCycle();
      done = !mInflight && !mDrain;
    end
    if (!done) failTimeout(tag);
  endtask

  function automatic logic [31:0] pickOp();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int r;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkEn = 1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_hi", hi_o, 32'h0);
    checkOutput("rst_lo", lo_o, 32'h0);
    checkOutput("rst_stall", stall_o, 1'b0);
    checkOutput("rst_opn", mul_opn_valid, 1'b0);
    checkOutput("rst_rdy", mul_res_ready, 1'b0);
    nextCycle();

    $display("[TB] MULTU max x 2");
    runInstr(1, 0, 32'hFFFFFFFF, 32'd2, 2'b00, 0, 0, 0, 1, 0, "t1");
    waitIdle("t1_idle");
    checkOutput("t1_hi", hi_o, 32'h00000001);
    checkOutput("t1_lo", lo_o, 32'hFFFFFFFE);

    $display("[TB] MULT -3 x 5");
    runInstr(1, 1, 32'hFFFFFFFD, 32'd5, 2'b00, 0, 0, 0, 1, 0, "t2");
    waitIdle("t2_idle");
    checkOutput("t2_hi", hi_o, 32'hFFFFFFFF);
    checkOutput("t2_lo", lo_o, 32'hFFFFFFF1);

    $display("[TB] flush in WAIT");
    runInstr(0, 0, 0, 0, 0, 1, 0, 32'h11111111, 0, 0, "t3_mthi");
    runInstr(0, 0, 0, 0, 0, 0, 1, 32'h22222222, 0, 0, "t3_mtlo");
    runInstr(1, 1, 32'h1234, 32'h5678, 2'b00, 0, 0, 0, 0, 0, "t3_mul");
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    waitIdle("t3_idle");
    checkOutput("t3_hi", hi_o, 32'h11111111);
    checkOutput("t3_lo", lo_o, 32'h22222222);

    $display("[TB] MTHI behind a multiply, back-to-back MULT");
    runInstr(1, 0, 32'd9, 32'd9, 2'b00, 0, 0, 0, 0, 0, "t4_mul");
    runInstr(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, "t4_mthi");
    waitIdle("t4_idle");
    checkOutput("t4_hi", hi_o, 32'hDEADBEEF);
    checkOutput("t4_lo", lo_o, 32'h00000051);
    runInstr(1, 0, 32'd6, 32'd7, 2'b00, 0, 0, 0, 1, 0, "t4_a");
    runInstr(1, 0, 32'h10000, 32'h10000, 2'b00, 0, 0, 0, 1, 0, "t4_b");
    waitIdle("t4_idle2");
    checkOutput("t4b_hi", hi_o, 32'h00000001);
    checkOutput("t4b_lo", lo_o, 32'h00000000);

    $display("[TB] reset in WAIT");
    runInstr(1, 0, 32'd3, 32'd3, 2'b00, 0, 0, 0, 0, 0, "t5_mul");
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_hi", hi_o, 32'h0);
    checkOutput("t5_lo", lo_o, 32'h0);
    checkOutput("t5_rdy", mul_res_ready, 1'b0);
    checkOutput("t5_stall", stall_o, 1'b0);
    nextCycle();

    $display("[TB] MSUBU 3 x 7 from HI/LO 0/0x10");
    runInstr(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0, "t6_mt");
    runInstr(0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0, "t6_mtlo");
    runInstr(1, 0, 32'd3, 32'd7, 2'b10, 0, 0, 0, 1, 0, "t6_mul");
    waitIdle("t6_idle");
    checkOutput("t6_hi", hi_o, MacEn ? 32'hFFFFFFFF : 32'h0);
    checkOutput("t6_lo", lo_o, MacEn ? 32'hFFFFFFFB : 32'h15);

    $display("[TB] random instruction stream");
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        runInstr(1, 1'($urandom_range(0, 1)), pickOp(), pickOp(), 2'($urandom_range(0, 3)),
                 0, 0, 0, 1'($urandom_range(0, 1)), 5, "rnd_mul");
      end else if (r <= 7) begin
        r = $urandom_range(1, 3);
        runInstr(0, 0, 0, 0, 0, r[0], r[1], pickOp(), 0, 5, "rnd_mt");
      end else if (r == 8) begin
        repeat ($urandom_range(1, 4)) nextCycle();
      end else if ($urandom_range(0, 3) == 0) begin
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
      end
    end
    waitIdle("rnd_idle");
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sits between the EX stage and the multi-cycle multiplier, which it feeds and consumes.
- Accepts multiply requests from EX and stalls the pipeline while one is in flight.
- Issues a single-cycle start pulse to the multiplier and collects its 64-bit product through the valid/ready handshake.
- Owns the architectural HI/LO registers and applies MTHI/MTLO writes in program order with respect to multiplies.

Parameters:
DATA_W, 32, operand and HI/LO width; the product is 2*DATA_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
ex_mul_req  in  1  EX holds a MULT/MULTU (level; held while stall_o=1)
ex_mul_sign  in  1  1 = MULT (signed), 0 = MULTU
ex_a  in  DATA_W  multiplicand
ex_b  in  DATA_W  multiplier
ex_mthi  in  1  EX holds MTHI
ex_mtlo  in  1  EX holds MTLO
ex_wdata  in  DATA_W  MTHI/MTLO data
ex_acc_op  in  2  00 none, 01 MADD(U), 10 MSUB(U), 11 reserved (acts as 00); used only with MULACC_EN
flush  in  1  kill the younger in-flight instruction (exception/eret)
stall_o  out  1  combinational; stall EX and everything older
mul_opn_valid  out  1  start pulse to the multiplier
mul_a  out  DATA_W  latched operand a
mul_b  out  DATA_W  latched operand b
mul_sign  out  1  latched sign
mul_res_valid  in  1  product valid
mul_res_ready  out  1  controller ready for the product
mul_result  in  2*DATA_W  product
hi_o  out  DATA_W  HI register
lo_o  out  DATA_W  LO register

Behaviour:
- Reset values: hi_o=0, lo_o=0, mul_opn_valid=0, mul_res_ready=0, mul_a=0, mul_b=0, mul_sign=0, state=IDLE, kill=0.
- States: IDLE, ISSUE, WAIT, DRAIN (2-bit encoding).
- IDLE:
  - ex_mul_req && !flush: latch ex_a, ex_b, ex_mul_sign (and ex_acc_op) into mul_a, mul_b, mul_sign, acc_q; go to ISSUE.
  - Else ex_mthi/ex_mtlo && !flush: write ex_wdata into HI/LO at the next edge.
  - If ex_mul_req and ex_mthi/ex_mtlo are both high, the multiply wins and the MT write is dropped (decoder never produces this).
- ISSUE:
  - mul_opn_valid=1 for exactly this one cycle; it is never held longer, so the multiplier cannot restart.
  - Go to WAIT.
- WAIT:
  - mul_res_ready=1.
  - On mul_res_valid: if kill=0, commit at the next edge: {hi_o,lo_o} <= mul_result (or the accumulate result; see Optional Feature). Go to DRAIN.
- DRAIN:
  - mul_res_ready stays 1 (the multiplier keeps res_valid high 1–3 cycles after the handshake).
  - Ignore mul_res_valid as data; no second commit.
  - When mul_res_valid=0: go to IDLE and clear kill.
- stall_o:
  - = (state==ISSUE || state==WAIT) && (ex_mul_req || ex_mthi || ex_mtlo || ex_busy_hilo), where ex_busy_hilo = 1. In effect, stall whenever ISSUE/WAIT.
  - Also | (state==DRAIN && ex_mul_req).
  - Also | (state==IDLE && ex_mul_req && !flush), so EX holds until the product commits.
  - stall_o=0 in the cycle after the commit edge (state DRAIN). MT writes are accepted during DRAIN because the commit has already happened.
- flush:
  - In ISSUE/WAIT: set kill; the handshake still completes, no HI/LO write, state still runs ISSUE→WAIT→DRAIN→IDLE.
  - In IDLE: suppresses acceptance of a multiply or MT.
  - flush forces stall_o=0.
- Latency: request seen in IDLE (cycle 0) → ISSUE (1) → WAIT (2..) → commit at the edge after the first mul_res_valid in WAIT.
- Reset mid-operation: everything returns to reset values the next edge. The multiplier shares rst, so no drain is needed.
- Width: the unsigned/signed distinction lives in the multiplier; the controller treats mul_result as a raw 64-bit value.

Optional Feature:
MULACC_EN
- Defined: acc_q=01 commits {hi_o,lo_o} + mul_result; acc_q=10 commits {hi_o,lo_o} - mul_result. Both are modulo 2^64. The HI/LO value used is the one at commit time.
- Undefined: ex_acc_op is ignored; every commit is a plain overwrite. The port remains present but unused.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=2 → one-cycle mul_opn_valid; stall_o high until commit; hi_o=0x00000001, lo_o=0xFFFFFFFE; exactly one commit despite multi-cycle res_valid.
2. MULT a=-3 (0xFFFFFFFD), b=5 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
3. MULT in flight, flush pulsed in WAIT → HI/LO keep their old values (e.g. 0x11111111/0x22222222); FSM returns to IDLE only after mul_res_valid drops.
4. MTHI 0xDEADBEEF requested during WAIT → stalled, applied after the commit (hi_o=0xDEADBEEF in the end); back-to-back MULT requests during DRAIN are stalled, then the second issues normally.
5. rst asserted in WAIT → next cycle state=IDLE, hi_o=lo_o=0, mul_res_ready=0, stall_o=0.
6. With MULACC_EN: HI/LO=0x0/0x00000010, MSUBU 3×7 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFB; without the macro the same stimulus gives 0x0/0x15.
